// File: rtl/cpu_fetch_if.sv
`default_nettype none
// ============================================================================
//  Module      : cpu_fetch_pkg / cpu_fetch_if
//  Description : Shared fetch types and the instruction-bus interface used by
//                cpu_fetch.
//                fetch_data_t : record handed to pre-decode. Fetch fills in
//                               .pc and .instruction and ties the remaining
//                               fields to 0; later stages may set them.
//                cpu_fetch_if : single-outstanding read bus.
//                  o_bus_request  fetch -> memory, read request
//                  o_bus_address  fetch -> memory, word-aligned address
//                  i_bus_ready    memory -> fetch, read complete this cycle
//                  i_bus_rdata    memory -> fetch, read data (valid with ready)
//                  modport master : fetch side
//                  modport slave  : memory side
//  Revision    : 1.0 - initial release
// ============================================================================

package cpu_fetch_pkg;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instruction;
        logic        predicted_taken;
        logic        access_fault;
    } fetch_data_t;

endpackage : cpu_fetch_pkg

interface cpu_fetch_if;

    logic        o_bus_request;
    logic [31:0] o_bus_address;
    logic        i_bus_ready;
    logic [31:0] i_bus_rdata;

    modport master (
        output o_bus_request,
        output o_bus_address,
        input  i_bus_ready,
        input  i_bus_rdata
    );

    modport slave (
        input  o_bus_request,
        input  o_bus_address,
        output i_bus_ready,
        output i_bus_rdata
    );

endinterface : cpu_fetch_if

`default_nettype wire

// File: rtl/cpu_fetch.sv
`default_nettype none
// ============================================================================
//  Module      : cpu_fetch
//  Description : Instruction fetch stage. Issues one word read at a time on
//                the instruction bus, presents the result to pre-decode with
//                a valid/stall handshake and redirects on jumps from execute.
//                Reads that were already issued when a jump arrives are let
//                to complete on the bus and their data is thrown away.
//  Ports       : i_clock        clock, rising edge
//                i_reset        synchronous reset, active low
//                i_jump         one-cycle redirect strobe
//                i_jump_pc      redirect target (bits [1:0] ignored)
//                bus            instruction bus, master side
//                o_valid        o_data holds a fetched instruction
//                i_stall        pre-decode not accepting
//                o_data         fetched {pc, instruction}, other fields 0
//                o_stall_cycles cycles with o_valid & i_stall
//                               (only with CPU_FETCH_STALL_COUNTER_EN)
//  Options     : `define CPU_FETCH_STALL_COUNTER_EN adds o_stall_cycles.
//  Revision    : 1.0 - initial release
// ============================================================================

module cpu_fetch
    import cpu_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_VECTOR = 32'h00000000
) (
    input  wire              i_clock,
    input  wire              i_reset,
    input  wire              i_jump,
    input  wire [31:0]       i_jump_pc,
    cpu_fetch_if.master      bus,
    output logic             o_valid,
    input  wire              i_stall,
    output fetch_data_t      o_data
`ifdef CPU_FETCH_STALL_COUNTER_EN
    ,
    output logic [31:0]      o_stall_cycles
`endif
);

    typedef enum logic [1:0] {
        S_REQUEST = 2'd0,
        S_DISCARD = 2'd1,
        S_OUTPUT  = 2'd2
    } state_t;

    localparam logic [31:0] c_PC_STEP = 32'd4;

    state_t      r_state;
    state_t      w_state_next;
    logic [31:0] r_pc;
    logic [31:0] w_pc_next;
    logic [31:0] r_target;
    logic [31:0] w_target_next;
    logic        r_valid;
    logic        w_valid_next;
    fetch_data_t r_data;
    fetch_data_t w_data_next;
    logic        w_bus_request;
    logic        w_accept;
    logic [31:0] w_jump_target;

    // Masking keeps every bit of i_jump_pc in use while forcing alignment.
    assign w_jump_target = i_jump_pc & 32'hFFFF_FFFC;
    assign w_accept      = r_valid & ~i_stall;

    // ------------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------------
    always_ff @(posedge i_clock) begin
        if (!i_reset) begin
            r_state  <= S_REQUEST;
            r_pc     <= RESET_VECTOR;
            r_target <= 32'h0;
            r_valid  <= 1'b0;
            r_data   <= '0;
        end else begin
            r_state  <= w_state_next;
            r_pc     <= w_pc_next;
            r_target <= w_target_next;
            r_valid  <= w_valid_next;
            r_data   <= w_data_next;
        end
    end

    // ------------------------------------------------------------------------
    // Next state and outputs
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_next  = r_state;
        w_pc_next     = r_pc;
        w_target_next = r_target;
        w_valid_next  = r_valid;
        w_data_next   = r_data;
        w_bus_request = 1'b0;

        unique case (r_state)
            S_REQUEST: begin
                w_bus_request = 1'b1;
                if (bus.i_bus_ready) begin
                    if (i_jump) begin
                        // Data belongs to the old path: drop it and restart.
                        w_pc_next    = w_jump_target;
                        w_state_next = S_REQUEST;
                    end else begin
                        w_data_next             = '0;
                        w_data_next.pc          = r_pc;
                        w_data_next.instruction = bus.i_bus_rdata;
                        w_valid_next            = 1'b1;
                        w_state_next            = S_OUTPUT;
                    end
                end else if (i_jump) begin
                    // Read already on the bus; let it finish, then redirect.
                    w_target_next = w_jump_target;
                    w_state_next  = S_DISCARD;
                end
            end

            S_DISCARD: begin
                // Request and address (r_pc) stay as issued until ready.
                w_bus_request = 1'b1;
                if (bus.i_bus_ready) begin
                    w_pc_next    = i_jump ? w_jump_target : r_target;
                    w_state_next = S_REQUEST;
                end else if (i_jump) begin
                    w_target_next = w_jump_target;
                end
            end

            S_OUTPUT: begin
                if (i_jump) begin
                    // Jump wins over stall; the held word is never accepted.
                    w_valid_next = 1'b0;
                    w_pc_next    = w_jump_target;
                    w_state_next = S_REQUEST;
                end else if (w_accept) begin
                    w_valid_next = 1'b0;
                    w_pc_next    = r_pc + c_PC_STEP;
                    w_state_next = S_REQUEST;
                end
            end

            default: begin
                w_state_next = S_REQUEST;
            end
        endcase
    end

    // Request is withdrawn combinationally while reset is held, since the
    // registered state reads REQUEST during reset.
    assign bus.o_bus_request = w_bus_request & i_reset;
    assign bus.o_bus_address = r_pc;
    assign o_valid           = r_valid;
    assign o_data            = r_data;

`ifdef CPU_FETCH_STALL_COUNTER_EN
    logic [31:0] r_stall_cycles;

    always_ff @(posedge i_clock) begin
        if (!i_reset) begin
            r_stall_cycles <= 32'h0;
        end else if (r_valid && i_stall) begin
            r_stall_cycles <= r_stall_cycles + 32'd1;
        end
    end

    assign o_stall_cycles = r_stall_cycles;
`endif

endmodule : cpu_fetch

`default_nettype wire

// File: tb/tb_cpu_fetch.sv
`default_nettype none
// ============================================================================
//  Module      : tb_cpu_fetch
//  Description : Self-checking bench for cpu_fetch. A cycle-by-cycle vector
//                table drives reset, bus and handshake inputs and states the
//                outputs expected in that cycle; short hand-written sequences
//                follow for jump-on-final-ready and reset while holding data.
//  Revision    : 1.0 - initial release
// ============================================================================

module tb_cpu_fetch;
    import cpu_fetch_pkg::*;

    localparam logic [31:0] c_RV = 32'h00001000;

    logic        clk;
    logic        r_reset;
    logic        r_jump;
    logic [31:0] r_jump_pc;
    logic        r_stall;
    logic        w_valid;
    fetch_data_t w_data;
`ifdef CPU_FETCH_STALL_COUNTER_EN
    logic [31:0] w_stall_cycles;
`endif

    int n_checks = 0;
    int n_errors = 0;

    cpu_fetch_if bus ();

    cpu_fetch #(
        .RESET_VECTOR (c_RV)
    ) dut (
        .i_clock        (clk),
        .i_reset        (r_reset),
        .i_jump         (r_jump),
        .i_jump_pc      (r_jump_pc),
        .bus            (bus),
        .o_valid        (w_valid),
        .i_stall        (r_stall),
        .o_data         (w_data)
`ifdef CPU_FETCH_STALL_COUNTER_EN
        ,
        .o_stall_cycles (w_stall_cycles)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic        jump;
        logic [31:0] jpc;
        logic        ready;
        logic [31:0] rdata;
        logic        stall;
        logic        e_req;
        logic [31:0] e_addr;
        logic        e_valid;
        logic        chk_data;
        logic [31:0] e_pc;
        logic [31:0] e_instr;
    } vec_t;

    localparam int c_NV = 31;
    vec_t tv [c_NV];

    function automatic vec_t mk(
        input logic rst, input logic jump, input logic [31:0] jpc,
        input logic ready, input logic [31:0] rdata, input logic stall,
        input logic e_req, input logic [31:0] e_addr, input logic e_valid,
        input logic chk_data, input logic [31:0] e_pc, input logic [31:0] e_instr);
        vec_t v;
        v.rst = rst; v.jump = jump; v.jpc = jpc; v.ready = ready;
        v.rdata = rdata; v.stall = stall; v.e_req = e_req; v.e_addr = e_addr;
        v.e_valid = e_valid; v.chk_data = chk_data; v.e_pc = e_pc;
        v.e_instr = e_instr;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %08h, expected %08h", name, act, exp);
        end
    endtask

    task automatic drive(input logic rst, input logic jump, input logic [31:0] jpc,
                         input logic ready, input logic [31:0] rdata, input logic stall);
        r_reset         = rst;
        r_jump          = jump;
        r_jump_pc       = jpc;
        bus.i_bus_ready = ready;
        bus.i_bus_rdata = rdata;
        r_stall         = stall;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_data(input string tag, input logic [31:0] e_pc, input logic [31:0] e_instr);
        check({tag, ".pc"}, w_data.pc, e_pc);
        check({tag, ".instr"}, w_data.instruction, e_instr);
        check({tag, ".other"}, {30'h0, w_data.predicted_taken, w_data.access_fault}, 32'h0);
    endtask

    initial begin
        // Cycle-by-cycle table; outputs are those seen during that cycle.
        //            rst jmp jpc           rdy rdata         stl  req addr          vld chk pc            instr
        tv[0]  = mk(0, 0, 32'h0,        0, 32'h0,        0,   0, 32'h0,        0,  1, 32'h0,        32'h0);
        tv[1]  = mk(0, 0, 32'h0,        1, 32'h0000FFFF, 0,   0, 32'h0,        0,  1, 32'h0,        32'h0);
        tv[2]  = mk(1, 0, 32'h0,        0, 32'h0,        0,   1, 32'h00001000, 0,  0, 32'h0,        32'h0);
        tv[3]  = mk(1, 0, 32'h0,        1, 32'hA0000001, 0,   1, 32'h00001000, 0,  0, 32'h0,        32'h0);
        tv[4]  = mk(1, 0, 32'h0,        0, 32'h0,        0,   0, 32'h0,        1,  1, 32'h00001000, 32'hA0000001);
        tv[5]  = mk(1, 0, 32'h0,        0, 32'h0,        0,   1, 32'h00001004, 0,  0, 32'h0,        32'h0);
        tv[6]  = mk(1, 0, 32'h0,        1, 32'hA0000002, 0,   1, 32'h00001004, 0,  0, 32'h0,        32'h0);
        tv[7]  = mk(1, 0, 32'h0,        0, 32'h0,        0,   0, 32'h0,        1,  1, 32'h00001004, 32'hA0000002);
        tv[8]  = mk(1, 0, 32'h0,        0, 32'h0,        0,   1, 32'h00001008, 0,  0, 32'h0,        32'h0);
        tv[9]  = mk(1, 0, 32'h0,        1, 32'hA0000003, 0,   1, 32'h00001008, 0,  0, 32'h0,        32'h0);
        for (int i = 10; i < 15; i++)
            tv[i] = mk(1, 0, 32'h0,     0, 32'h0,        1,   0, 32'h0,        1,  1, 32'h00001008, 32'hA0000003);
        tv[15] = mk(1, 0, 32'h0,        0, 32'h0,        0,   0, 32'h0,        1,  1, 32'h00001008, 32'hA0000003);
        tv[16] = mk(1, 1, 32'h00002003, 0, 32'h0,        0,   1, 32'h0000100C, 0,  0, 32'h0,        32'h0);
        tv[17] = mk(1, 0, 32'h0,        0, 32'h0,        0,   1, 32'h0000100C, 0,  0, 32'h0,        32'h0);
        tv[18] = mk(1, 0, 32'h0,        0, 32'h0,        0,   1, 32'h0000100C, 0,  0, 32'h0,        32'h0);
        tv[19] = mk(1, 0, 32'h0,        1, 32'hDEADBEEF, 0,   1, 32'h0000100C, 0,  0, 32'h0,        32'h0);
        tv[20] = mk(1, 1, 32'h00003000, 0, 32'h0,        0,   1, 32'h00002000, 0,  0, 32'h0,        32'h0);
        tv[21] = mk(1, 1, 32'h00004000, 0, 32'h0,        0,   1, 32'h00002000, 0,  0, 32'h0,        32'h0);
        tv[22] = mk(1, 0, 32'h0,        1, 32'hBAD0BAD0, 0,   1, 32'h00002000, 0,  0, 32'h0,        32'h0);
        tv[23] = mk(1, 0, 32'h0,        1, 32'h11111111, 0,   1, 32'h00004000, 0,  0, 32'h0,        32'h0);
        tv[24] = mk(1, 1, 32'h00005000, 0, 32'h0,        1,   0, 32'h0,        1,  1, 32'h00004000, 32'h11111111);
        tv[25] = mk(1, 1, 32'hFFFFFFFE, 1, 32'h33333333, 1,   1, 32'h00005000, 0,  0, 32'h0,        32'h0);
        tv[26] = mk(1, 0, 32'h0,        1, 32'h22222222, 0,   1, 32'hFFFFFFFC, 0,  0, 32'h0,        32'h0);
        tv[27] = mk(1, 0, 32'h0,        0, 32'h0,        0,   0, 32'h0,        1,  1, 32'hFFFFFFFC, 32'h22222222);
        tv[28] = mk(1, 0, 32'h0,        0, 32'h0,        0,   1, 32'h00000000, 0,  0, 32'h0,        32'h0);
        tv[29] = mk(0, 0, 32'h0,        0, 32'h0,        0,   0, 32'h0,        0,  0, 32'h0,        32'h0);
        tv[30] = mk(1, 0, 32'h0,        0, 32'h0,        0,   1, 32'h00001000, 0,  0, 32'h0,        32'h0);

        drive(0, 0, 32'h0, 0, 32'h0, 0);
        tick();
        tick();

        for (int i = 0; i < c_NV; i++) begin
            drive(tv[i].rst, tv[i].jump, tv[i].jpc, tv[i].ready, tv[i].rdata, tv[i].stall);
            #1;
            check($sformatf("v%0d.req", i), {31'h0, bus.o_bus_request}, {31'h0, tv[i].e_req});
            check($sformatf("v%0d.valid", i), {31'h0, w_valid}, {31'h0, tv[i].e_valid});
            if (tv[i].e_req)
                check($sformatf("v%0d.addr", i), bus.o_bus_address, tv[i].e_addr);
            if (tv[i].chk_data)
                check_data($sformatf("v%0d.data", i), tv[i].e_pc, tv[i].e_instr);
`ifdef CPU_FETCH_STALL_COUNTER_EN
            if (i == 15) check("stall_cycles_5", w_stall_cycles, 32'd5);
            if (i == 25) check("stall_cycles_6", w_stall_cycles, 32'd6);
`endif
            tick();
        end

        // Jump landing in the same cycle as the final ready of DISCARD.
        drive(1, 1, 32'h00007000, 0, 32'h0, 0);
        #1;
        check("seqA.req0", {31'h0, bus.o_bus_request}, 32'h1);
        tick();
        drive(1, 1, 32'h00008000, 1, 32'h55555555, 0);
        #1;
        check("seqA.discard_addr", bus.o_bus_address, 32'h00001000);
        tick();
        drive(1, 0, 32'h0, 1, 32'h44444444, 0);
        #1;
        check("seqA.new_addr", bus.o_bus_address, 32'h00008000);
        check("seqA.no_stale", {31'h0, w_valid}, 32'h0);
        tick();
        drive(1, 0, 32'h0, 0, 32'h0, 1);
        #1;
        check("seqA.valid", {31'h0, w_valid}, 32'h1);
        check_data("seqA.data", 32'h00008000, 32'h44444444);
        tick();

        // Reset while holding a stalled instruction clears everything.
        drive(0, 0, 32'h0, 0, 32'h0, 1);
        #1;
        check("seqB.req_in_reset", {31'h0, bus.o_bus_request}, 32'h0);
        tick();
        check("seqB.valid", {31'h0, w_valid}, 32'h0);
        check_data("seqB.data", 32'h0, 32'h0);
`ifdef CPU_FETCH_STALL_COUNTER_EN
        check("seqB.stall_cycles", w_stall_cycles, 32'd0);
`endif
        drive(1, 0, 32'h0, 0, 32'h0, 0);
        #1;
        check("seqB.restart_req", {31'h0, bus.o_bus_request}, 32'h1);
        check("seqB.restart_addr", bus.o_bus_address, c_RV);
        tick();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule : tb_cpu_fetch

`default_nettype wire

// File: doc/cpu_fetch.md
CPU_FETCH -- requirements
Module: cpu_fetch

Interface
REQ-001 The block SHALL have parameter RESET_VECTOR, default 32'h00000000, giving the first fetch address after reset.
REQ-002 The block SHALL have port i_clock, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port i_reset, input, 1 bit: reset, synchronous and active-low (0 = reset).
REQ-004 The block SHALL have port i_jump, input, 1 bit: one-cycle redirect strobe from execute.
REQ-005 The block SHALL have port i_jump_pc, input, 32 bits: redirect target; bits [1:0] are ignored and treated as 0.
REQ-006 The block SHALL have port o_bus_request, output, 1 bit: instruction bus read request.
REQ-007 The block SHALL have port i_bus_ready, input, 1 bit: read complete, with i_bus_rdata valid in that cycle.
REQ-008 The block SHALL have port o_bus_address, output, 32 bits: word-aligned read address.
REQ-009 The block SHALL have port i_bus_rdata, input, 32 bits: read data.
REQ-010 The block SHALL have port o_valid, output, 1 bit: o_data holds a fetched instruction.
REQ-011 The block SHALL have port i_stall, input, 1 bit: downstream pre-decode not accepting.
REQ-012 The block SHALL have port o_data, output, fetch_data_t: .pc and .instruction populated, all other fields 0.

Function
REQ-013 The block SHALL implement states REQUEST, DISCARD and OUTPUT; accept = o_valid & ~i_stall.
REQ-014 In REQUEST, o_bus_request SHALL be 1 and o_bus_address SHALL be pc, held stable until i_bus_ready.
REQ-015 On REQUEST with i_bus_ready and no i_jump, the block SHALL capture {pc, i_bus_rdata} into o_data, set o_valid the next cycle and go to OUTPUT (ready-to-valid latency 1 cycle).
REQ-016 In OUTPUT, o_bus_request SHALL be 0, and o_data and o_valid SHALL be held unchanged while i_stall is 1.
REQ-017 On accept without i_jump, the block SHALL set pc to pc+4 (32-bit wrap, FFFFFFFC to 00000000), clear o_valid and go to REQUEST the next cycle.
REQ-018 On i_jump in REQUEST with i_bus_ready, the block SHALL drop the read data and go to REQUEST at {i_jump_pc[31:2],2'b00}.
REQ-019 On i_jump in REQUEST without i_bus_ready, the block SHALL latch the target and go to DISCARD.
REQ-020 DISCARD SHALL keep the outstanding request and its address until i_bus_ready, drop that data, then go to REQUEST at the latched target.
REQ-021 On i_jump in DISCARD, the block SHALL overwrite the latched target (latest wins); a jump coinciding with the final ready SHALL use the new target.
REQ-022 On i_jump in OUTPUT, regardless of i_stall, the block SHALL clear o_valid the next cycle and go to REQUEST at the target; the held instruction is never accepted afterwards.
REQ-023 o_valid SHALL never be 1 for data returned by a request issued before the most recent i_jump.

Reset
REQ-024 While i_reset=0, the block SHALL set state=REQUEST, pc=RESET_VECTOR, o_valid=0, o_data=0 and clear the latched target and counter; o_bus_request SHALL be 0 during reset.
REQ-025 The first request SHALL assert in the first cycle after i_reset rises, at RESET_VECTOR.
REQ-026 Reset mid-transaction SHALL abandon the outstanding read, and the bus SHALL tolerate a withdrawn request.

Configuration
REQ-027 With CPU_FETCH_STALL_COUNTER_EN defined, the block SHALL add output o_stall_cycles (32 bits), incrementing each cycle o_valid&i_stall, wrapping at 2^32 and reset to 0.
REQ-028 Without CPU_FETCH_STALL_COUNTER_EN, the port and counter SHALL be absent and all other behaviour SHALL be identical.

Verification
REQ-029 Reset release with RESET_VECTOR=32'h00001000 and ready on the 2nd request cycle -> address 00001000, o_valid 1 cycle later with pc=00001000 and instruction=rdata.
REQ-030 Three accepts with i_stall=0 and ready each request cycle -> pcs 00001000, 00001004, 00001008, o_valid every 3rd cycle.
REQ-031 i_stall=1 for 5 cycles in OUTPUT -> o_data unchanged, no request; with the macro enabled, o_stall_cycles=5.
REQ-032 i_jump with target 00002003 while the request waits 4 cycles for ready -> stale data dropped, next request at 00002000, no stale o_valid.
REQ-033 Two jumps in DISCARD (00003000 then 00004000) -> next request at 00004000.
REQ-034 i_jump in OUTPUT with i_stall=1, plus pc=FFFFFFFC accepted -> o_valid drops and next pc is 00000000; i_reset=0 mid-request -> o_bus_request=0 and restart at RESET_VECTOR.
